id_ex_reg: RTL and testbench

//   ID/EX pipeline register with integrated load-use hazard detection for the pipelined MIPS core.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/load_use_detect.sv | 32 +++
 rtl/id_ex_reg.sv | 136 +++++++++++++
 tb/tb_id_ex_reg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the pipelined MIPS core: ALU-op and funct codes, and
// the bundle of single-bit controls that travels down the pipeline.
package mips_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ADDI  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // An instruction slot that is not valid must not carry live control bits.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : CTRL_NOP;
  endfunction

  function automatic logic [1:0] gate_alu_op(input logic [1:0] op, input logic valid);
    return valid ? op : ALU_OP_ADD;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction currently in ID.
module load_use_detect #(
  parameter int RW = 5
) (
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_alu_src,
  input  logic          id_mem_write,
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic          flush,
  input  logic          ext_stall,
  output logic          hz_stall
);

  logic rs_match;
  logic rt_match;
  logic load_in_ex;

  // rt is only a true source when it is not replaced by the immediate, or
  // when it supplies store data.
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = (ex_rt == id_rt) && (!id_alu_src || id_mem_write);
  assign load_in_ex = ex_valid && ex_mem_read && (ex_rt != '0);

  assign hz_stall = id_valid && load_in_ex && !flush && !ext_stall &&
                    (rs_match || rt_match);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: carries decoded operands and controls into EX,
// inserts bubbles for flush and load-use, holds on downstream stall.
module id_ex_reg
  import mips_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [DW-1:0]   id_pc4,
  input  logic [DW-1:0]   id_rd1,
  input  logic [DW-1:0]   id_rd2,
  input  logic [DW-1:0]   id_imm,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_alu_src,
  input  logic            id_reg_dst,
  input  logic [1:0]      id_alu_op,
  input  logic            flush,
  input  logic            ext_stall,
  output logic            ex_valid,
  output logic [DW-1:0]   ex_pc4,
  output logic [DW-1:0]   ex_rd1,
  output logic [DW-1:0]   ex_rd2,
  output logic [DW-1:0]   ex_imm,
  output logic [RW-1:0]   ex_rs,
  output logic [RW-1:0]   ex_rt,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_alu_src,
  output logic            ex_reg_dst,
  output logic [1:0]      ex_alu_op,
  output logic [5:0]      ex_funct,
  output logic            hz_stall,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;

  assign id_ctrl = '{
    reg_write:  id_reg_write,
    mem_to_reg: id_mem_to_reg,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    branch:     id_branch,
    alu_src:    id_alu_src,
    reg_dst:    id_reg_dst
  };

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_dst    = ex_ctrl.reg_dst;

  load_use_detect #(.RW(RW)) u_load_use_detect (
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_alu_src   (id_alu_src),
    .id_mem_write (id_mem_write),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_ctrl.mem_read),
    .ex_rt        (ex_rt),
    .flush        (flush),
    .ext_stall    (ext_stall),
    .hz_stall     (hz_stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_pc4    <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= CTRL_NOP;
      ex_alu_op <= ALU_OP_ADD;
      ex_funct  <= '0;
      stall_cnt <= '0;
    end else begin
      if ((hz_stall || ext_stall) && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;

      // hz_stall is already masked by ext_stall, so flush is the only bubble
      // source that can coincide with a downstream hold.
      if (flush || hz_stall) begin
        ex_valid  <= 1'b0;
        ex_pc4    <= '0;
        ex_rd1    <= '0;
        ex_rd2    <= '0;
        ex_imm    <= '0;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_rd     <= '0;
        ex_ctrl   <= CTRL_NOP;
        ex_alu_op <= ALU_OP_ADD;
        ex_funct  <= '0;
      end else if (!ext_stall) begin
        ex_valid  <= id_valid;
        ex_pc4    <= id_pc4;
        ex_rd1    <= id_rd1;
        ex_rd2    <= id_rd2;
        ex_imm    <= id_imm;
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_rd     <= id_rd;
        ex_ctrl   <= gate_ctrl(id_ctrl, id_valid);
        ex_alu_op <= gate_alu_op(id_alu_op, id_valid);
        ex_funct  <= id_imm[5:0];
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a cycle-level reference model predicts the
// EX slot, hazard flag and stall counters; a monitor compares the DUT each cycle.
module tb_id_ex_reg;
  import mips_pkg::*;

  typedef struct {
    logic        valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [6:0]  ctrl;   // {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst}
    logic [1:0]  alu_op;
  } stage_t;

  typedef struct {
    logic   hz;
    stage_t ex;
    int     cnt;
    int     cnt4;
  } exp_t;

  localparam logic [6:0] C_RTYPE = 7'b1000001;
  localparam logic [6:0] C_LW    = 7'b1110010;
  localparam logic [6:0] C_ADDI  = 7'b1000010;
  localparam logic [6:0] C_SW    = 7'b0001010;
  localparam logic [6:0] C_BEQ   = 7'b0000100;

  logic clk = 1'b0;
  logic rst, id_valid, flush, ext_stall;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst;
  logic [1:0]  id_alu_op;

  logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [1:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic        hz_stall;
  logic [15:0] stall_cnt;

  logic s_valid, s_reg_write, s_mem_to_reg, s_mem_read, s_mem_write, s_branch, s_alu_src, s_reg_dst;
  logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [1:0]  s_alu_op;
  logic [5:0]  s_funct;
  logic        s_hz;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .flush(flush), .ext_stall(ext_stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .hz_stall(hz_stall),
    .stall_cnt(stall_cnt)
  );

  id_ex_reg #(.CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .flush(flush), .ext_stall(ext_stall), .ex_valid(s_valid), .ex_pc4(s_pc4), .ex_rd1(s_rd1),
    .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg), .ex_mem_read(s_mem_read),
    .ex_mem_write(s_mem_write), .ex_branch(s_branch), .ex_alu_src(s_alu_src),
    .ex_reg_dst(s_reg_dst), .ex_alu_op(s_alu_op), .ex_funct(s_funct), .hz_stall(s_hz),
    .stall_cnt(s_cnt)
  );

  int total = 0;
  int bad = 0;
  int pushed = 0;
  int popped = 0;
  bit done = 0;
  exp_t sbq[$];
  stage_t m_ex;
  int m_cnt, m_cnt4;
  logic last_hz;
  stage_t last_s;

  function automatic stage_t zero_stage();
    stage_t z;
    z.valid = 0; z.pc4 = 0; z.rd1 = 0; z.rd2 = 0; z.imm = 0;
    z.rs = 0; z.rt = 0; z.rd = 0; z.ctrl = 0; z.alu_op = 0;
    return z;
  endfunction

  function automatic stage_t instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [6:0] c, input logic [1:0] op,
                                   input logic [5:0] funct);
    stage_t s;
    s.valid = v; s.rs = rs; s.rt = rt; s.rd = rd; s.ctrl = c; s.alu_op = op;
    s.pc4 = $urandom; s.rd1 = $urandom; s.rd2 = $urandom;
    s.imm = {$urandom_range(0, 32'h03FF_FFFF), funct};
    return s;
  endfunction

  // A load in EX blocks the ID instruction if it truly reads the loaded register.
  function automatic logic model_hz(input stage_t ex, input stage_t id, input logic fl, input logic es);
    logic reads_rt;
    if (fl || es || !id.valid || !ex.valid || !ex.ctrl[4] || ex.rt == 5'd0) return 1'b0;
    reads_rt = (id.ctrl[1] == 1'b0) || (id.ctrl[3] == 1'b1);
    return (ex.rt == id.rs) || (reads_rt && ex.rt == id.rt);
  endfunction

  task automatic step(input stage_t s, input logic r, input logic fl, input logic es);
    exp_t e;
    logic hz;
    @(negedge clk);
    #1;
    rst = r; flush = fl; ext_stall = es;
    id_valid = s.valid; id_pc4 = s.pc4; id_rd1 = s.rd1; id_rd2 = s.rd2; id_imm = s.imm;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_alu_op = s.alu_op;
    {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst} = s.ctrl;
    hz = model_hz(m_ex, s, fl, es);
    e.hz = hz; e.ex = m_ex; e.cnt = m_cnt; e.cnt4 = m_cnt4;
    sbq.push_back(e);
    pushed++;
    if (r) begin
      m_ex = zero_stage(); m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (hz || es) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (fl || hz) m_ex = zero_stage();
      else if (!es) begin
        m_ex = s;
        if (!s.valid) begin m_ex.ctrl = 0; m_ex.alu_op = 0; end
      end
    end
    last_hz = hz;
    last_s = s;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stage_t rand_instr();
    int kind;
    logic v;
    logic [4:0] rs, rt, rd;
    v = ($urandom_range(0, 9) != 0);
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    kind = $urandom_range(0, 4);
    case (kind)
      0: return instr(v, rs, rt, rd, C_RTYPE, ALU_OP_RTYPE, 6'($urandom));
      1: return instr(v, rs, rt, rd, C_LW, ALU_OP_ADD, 6'($urandom));
      2: return instr(v, rs, rt, rd, C_ADDI, ALU_OP_ADDI, 6'($urandom));
      3: return instr(v, rs, rt, rd, C_SW, ALU_OP_ADD, 6'($urandom));
      default: return instr(v, rs, rt, rd, C_BEQ, ALU_OP_SUB, 6'($urandom));
    endcase
  endfunction

  task automatic driver();
    stage_t lw5, add65, s;
    // reset with garbage on ID
    for (int i = 0; i < 3; i++) step(rand_instr(), 1'b1, 1'b0, 1'b0);
    // pass-through of an R-type add
    step(instr(1'b1, 5'd1, 5'd2, 5'd3, C_RTYPE, ALU_OP_RTYPE, FUNCT_ADD), 1'b0, 1'b0, 1'b0);
    step(instr(1'b1, 5'd4, 5'd7, 5'd2, C_RTYPE, ALU_OP_RTYPE, FUNCT_SUB), 1'b0, 1'b0, 1'b0);
    // load-use: lw $5 then add $6,$5,$1, re-presented after the bubble
    lw5 = instr(1'b1, 5'd2, 5'd5, 5'd0, C_LW, ALU_OP_ADD, 6'h10);
    add65 = instr(1'b1, 5'd5, 5'd1, 5'd6, C_RTYPE, ALU_OP_RTYPE, FUNCT_ADD);
    step(lw5, 1'b0, 1'b0, 1'b0);
    step(add65, 1'b0, 1'b0, 1'b0);
    step(add65, 1'b0, 1'b0, 1'b0);
    step(instr(1'b1, 5'd3, 5'd4, 5'd1, C_RTYPE, ALU_OP_RTYPE, FUNCT_OR), 1'b0, 1'b0, 1'b0);
    // lw $0 never hazards
    step(instr(1'b1, 5'd2, 5'd0, 5'd0, C_LW, ALU_OP_ADD, 6'h04), 1'b0, 1'b0, 1'b0);
    step(instr(1'b1, 5'd0, 5'd0, 5'd6, C_RTYPE, ALU_OP_RTYPE, FUNCT_AND), 1'b0, 1'b0, 1'b0);
    // addi using $5 only as rt (destination) does not hazard; sw with rt=$5 does
    step(lw5, 1'b0, 1'b0, 1'b0);
    step(instr(1'b1, 5'd1, 5'd5, 5'd0, C_ADDI, ALU_OP_ADDI, 6'h3F), 1'b0, 1'b0, 1'b0);
    step(lw5, 1'b0, 1'b0, 1'b0);
    step(instr(1'b1, 5'd1, 5'd5, 5'd0, C_SW, ALU_OP_ADD, 6'h08), 1'b0, 1'b0, 1'b0);
    step(last_s, 1'b0, 1'b0, 1'b0);
    // flush wins over ext_stall
    step(instr(1'b1, 5'd1, 5'd2, 5'd3, C_RTYPE, ALU_OP_RTYPE, FUNCT_SLT), 1'b0, 1'b0, 1'b0);
    step(rand_instr(), 1'b0, 1'b1, 1'b1);
    // ext_stall hold for 4 cycles
    step(instr(1'b1, 5'd6, 5'd7, 5'd1, C_RTYPE, ALU_OP_RTYPE, FUNCT_ADD), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(rand_instr(), 1'b0, 1'b0, 1'b1);
    step(rand_instr(), 1'b0, 1'b0, 1'b0);
    // saturation of the narrow counter
    for (int i = 0; i < 20; i++) step(rand_instr(), 1'b0, 1'b0, 1'b1);
    step(rand_instr(), 1'b0, 1'b0, 1'b0);
    // reset while a load-use stall is active
    step(lw5, 1'b0, 1'b0, 1'b0);
    step(add65, 1'b1, 1'b0, 1'b0);
    step(add65, 1'b0, 1'b0, 1'b0);
    step(rand_instr(), 1'b0, 1'b0, 1'b0);
    // random traffic; ID re-presents its instruction while a load-use stall holds it
    for (int i = 0; i < 2000; i++) begin
      s = last_hz ? last_s : rand_instr();
      step(s, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
    end
    @(negedge clk);
    done = 1;
  endtask

  task automatic monitor();
    exp_t e;
    while (!done || sbq.size() > 0) begin
      @(negedge clk);
      #3;
      if (sbq.size() == 0) continue;
      e = sbq.pop_front();
      popped++;
      check("hz_stall", {31'd0, hz_stall}, {31'd0, e.hz});
      check("ex_valid", {31'd0, ex_valid}, {31'd0, e.ex.valid});
      check("ex_pc4", ex_pc4, e.ex.pc4);
      check("ex_rd1", ex_rd1, e.ex.rd1);
      check("ex_rd2", ex_rd2, e.ex.rd2);
      check("ex_imm", ex_imm, e.ex.imm);
      check("ex_rs", {27'd0, ex_rs}, {27'd0, e.ex.rs});
      check("ex_rt", {27'd0, ex_rt}, {27'd0, e.ex.rt});
      check("ex_rd", {27'd0, ex_rd}, {27'd0, e.ex.rd});
      check("ex_ctrl", {25'd0, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch,
                        ex_alu_src, ex_reg_dst}, {25'd0, e.ex.ctrl});
      check("ex_alu_op", {30'd0, ex_alu_op}, {30'd0, e.ex.alu_op});
      check("ex_funct", {26'd0, ex_funct}, {26'd0, e.ex.imm[5:0]});
      check("stall_cnt", {16'd0, stall_cnt}, 32'(e.cnt));
      check("stall_cnt_w4", {28'd0, s_cnt}, 32'(e.cnt4));
      check("hz_stall_w4", {31'd0, s_hz}, {31'd0, e.hz});
    end
  endtask

  initial begin
    m_ex = zero_stage(); m_cnt = 0; m_cnt4 = 0; last_hz = 0; last_s = zero_stage();
    rst = 1; flush = 0; ext_stall = 0; id_valid = 0;
    id_pc4 = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 0;
    {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst} = 7'd0;
    fork
      driver();
      monitor();
    join
    check("scoreboard_drain", 32'(popped), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, popped=%0d pushed=%0d", popped, pushed);
    $fatal(1, "timeout");
  end

endmodule
